// File: rtl/spring_bank.sv
// spring_bank -- a bank of N_SPRINGS independent jump springs for a scrolling
// platformer.
//
// Each spring has a position, a valid bit and a small FSM:
// IDLE -> COMPRESS -> LAUNCH -> COOLDOWN -> IDLE.
// A spring compresses while the character stands exactly on top of it. It
// launches once it has been held for HOLD_TICKS frames, then stays inert for
// COOLDOWN_TICKS frames. All FSM and counter advances happen only on
// frame_tick. Placement writes (cfg_we) take effect on any clock edge.
//
// Ports
//   sys_clk             : system clock; all state changes on the rising edge
//   rst                 : asynchronous, active-high reset
//   frame_tick          : one-cycle game-update strobe
//   char_X, char_Y      : top-left corner of the character
//   scroll_left_border  : left edge of the visible window
//   scroll_right_border : right edge of the visible window
//   jump_btn            : player jump button (level); a press during
//                         compression requests a high jump
//   cfg_we/idx/X/Y/valid: write the placement of spring cfg_idx
//   jump                : one-cycle launch pulse (registered)
//   jump_high           : launch strength, valid with jump
//   active_idx          : index of the launching spring, valid with jump
//   spring_compressed   : per-spring flag, high in COMPRESS and LAUNCH
module spring_bank #(
  parameter int N_SPRINGS      = 4,
  parameter int COORD_W        = 9,
  parameter int SPRING_SIZE    = 16,
  parameter int CHAR_SIZE      = 16,
  parameter int HOLD_TICKS     = 4,
  parameter int COOLDOWN_TICKS = 8,
  localparam int IDX_W         = (N_SPRINGS > 1) ? $clog2(N_SPRINGS) : 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [COORD_W-1:0]   char_X,
  input  logic [COORD_W-1:0]   char_Y,
  input  logic [COORD_W-1:0]   scroll_left_border,
  input  logic [COORD_W-1:0]   scroll_right_border,
  input  logic                 jump_btn,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [COORD_W-1:0]   cfg_X,
  input  logic [COORD_W-1:0]   cfg_Y,
  input  logic                 cfg_valid,
  output logic                 jump,
  output logic                 jump_high,
  output logic [IDX_W-1:0]     active_idx,
  output logic [N_SPRINGS-1:0] spring_compressed
);

  // Durations of 0 are treated as 1 tick.
  localparam int HOLD_EFF = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
  localparam int CD_EFF   = (COOLDOWN_TICKS < 1) ? 1 : COOLDOWN_TICKS;
  localparam int MAX_T    = (HOLD_EFF > CD_EFF) ? HOLD_EFF : CD_EFF;
  localparam int CNT_W    = $clog2(MAX_T + 1) + 1;

  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_EFF - 1);
  localparam logic [CNT_W-1:0]   CD_LAST   = CNT_W'(CD_EFF - 1);
  localparam logic [COORD_W:0]   SPR_EXT   = (COORD_W + 1)'(SPRING_SIZE);
  localparam logic [COORD_W:0]   CHR_EXT   = (COORD_W + 1)'(CHAR_SIZE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPRESS = 2'd1,
    LAUNCH   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  logic [N_SPRINGS-1:0] launch_vec;    // spring enters LAUNCH on this edge
  logic [N_SPRINGS-1:0] strength_vec;  // strength latch as it will be stored

  // Character extents are shared by every spring; one extra bit keeps the
  // sums from wrapping near the top of the coordinate range.
  logic [COORD_W:0] char_x_end;
  logic [COORD_W:0] char_y_end;

  assign char_x_end = {1'b0, char_X} + CHR_EXT;
  assign char_y_end = {1'b0, char_Y} + CHR_EXT;

  genvar gi;
  generate
    for (gi = 0; gi < N_SPRINGS; gi++) begin : g_spring
      logic [COORD_W-1:0] x_reg;
      logic [COORD_W-1:0] y_reg;
      logic               valid_reg;
      state_t             state_reg;
      state_t             state_next;
      logic [CNT_W-1:0]   cnt_reg;
      logic [CNT_W-1:0]   cnt_next;
      logic [CNT_W-1:0]   cnt_inc;
      logic               latch_reg;
      logic               latch_next;
      logic               compressed_reg;
      logic               cfg_hit;
      logic               enabled;
      logic               contact;
      logic               go;
      logic [COORD_W:0]   x_end;

      // Indices beyond N_SPRINGS match no generate instance and are dropped.
      assign cfg_hit = cfg_we && (cfg_idx == IDX_W'(gi));
      assign x_end   = {1'b0, x_reg} + SPR_EXT;

      // A spring is live only while some part of it is inside the window.
      assign enabled = valid_reg
                    && (x_reg <= scroll_right_border)
                    && (x_end >= {1'b0, scroll_left_border});

      // Standing exactly on top, horizontal overlap inclusive at both edges.
      assign contact = enabled
                    && (char_y_end == {1'b0, y_reg})
                    && (char_x_end >= {1'b0, x_reg})
                    && ({1'b0, char_X} <= x_end);

      assign cnt_inc = cnt_reg + CNT_W'(1);

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        latch_next = latch_reg;
        go         = 1'b0;
        if (cfg_hit) begin
          // Re-placing a spring aborts whatever it was doing, launch included.
          state_next = IDLE;
          cnt_next   = '0;
          latch_next = 1'b0;
        end else if (frame_tick) begin
          unique case (state_reg)
            IDLE: begin
              if (contact) begin
                state_next = COMPRESS;
                cnt_next   = '0;
                latch_next = jump_btn;
              end
            end
            COMPRESS: begin
              if (!contact) begin
                state_next = IDLE;
                cnt_next   = '0;
              end else begin
                latch_next = latch_reg | jump_btn;
                cnt_next   = cnt_inc;
                if (cnt_inc >= HOLD_LAST) begin
                  state_next = LAUNCH;
                  go         = 1'b1;
                end
              end
            end
            LAUNCH: begin
              state_next = COOLDOWN;
              cnt_next   = '0;
            end
            COOLDOWN: begin
              // Contact and window position are deliberately ignored here.
              cnt_next = cnt_inc;
              if (cnt_inc >= CD_LAST) begin
                state_next = IDLE;
                cnt_next   = '0;
              end
            end
          endcase
        end
      end

      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
          x_reg          <= '0;
          y_reg          <= '0;
          valid_reg      <= 1'b0;
          state_reg      <= IDLE;
          cnt_reg        <= '0;
          latch_reg      <= 1'b0;
          compressed_reg <= 1'b0;
        end else begin
          if (cfg_hit) begin
            x_reg     <= cfg_X;
            y_reg     <= cfg_Y;
            valid_reg <= cfg_valid;
          end
          state_reg      <= state_next;
          cnt_reg        <= cnt_next;
          latch_reg      <= latch_next;
          compressed_reg <= (state_next == COMPRESS) || (state_next == LAUNCH);
        end
      end

      assign launch_vec[gi]        = go;
      assign strength_vec[gi]      = latch_next;
      assign spring_compressed[gi] = compressed_reg;
    end
  endgenerate

  // The lowest launching index wins the single shared jump pulse. Other
  // springs launching on the same edge still proceed to COOLDOWN.
  logic [IDX_W-1:0] win_idx;
  logic             win_high;
  logic             any_launch;

  always_comb begin
    win_idx  = '0;
    win_high = 1'b0;
    for (int i = N_SPRINGS - 1; i >= 0; i--) begin
      if (launch_vec[i]) begin
        win_idx  = IDX_W'(i);
        win_high = strength_vec[i];
      end
    end
  end

  assign any_launch = |launch_vec;

  // Launches only occur on frame_tick edges, so the pulse is one cycle wide.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      jump       <= 1'b0;
      jump_high  <= 1'b0;
      active_idx <= '0;
    end else begin
      jump       <= any_launch;
      jump_high  <= any_launch & win_high;
      active_idx <= any_launch ? win_idx : '0;
    end
  end

endmodule

// File: doc/spring_bank.md
SPRING_BANK -- requirements
Module: spring_bank

Interface
REQ-001 SHALL have parameter N_SPRINGS, default 4: number of independent springs (1..16).
REQ-002 SHALL have parameter COORD_W, default 9: width of all coordinates.
REQ-003 SHALL have parameter SPRING_SIZE, default 16: spring edge length, pixels.
REQ-004 SHALL have parameter CHAR_SIZE, default 16: character edge length, pixels.
REQ-005 SHALL have parameter HOLD_TICKS, default 4: frame ticks a spring stays compressed before launch.
REQ-006 SHALL have parameter COOLDOWN_TICKS, default 8: frame ticks a spring is inert after launch.
REQ-007 SHALL have port sys_clk  in  1  system clock; all state updates on rising edge.
REQ-008 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have port frame_tick  in  1  one-cycle game-update strobe; all FSM and counter advances qualify on it.
REQ-010 SHALL have ports char_X, char_Y  in  COORD_W each  absolute character top-left.
REQ-011 SHALL have ports scroll_left_border, scroll_right_border  in  COORD_W each  visible window.
REQ-012 SHALL have port jump_btn  in  1  player jump button, level.
REQ-013 SHALL have ports cfg_we  in  1;  cfg_idx  in  clog2(N_SPRINGS) (min 1);  cfg_X, cfg_Y  in  COORD_W;  cfg_valid  in  1  spring placement write.
REQ-014 SHALL have port jump  out  1  one-cycle launch pulse.
REQ-015 SHALL have port jump_high  out  1  launch strength, valid with jump.
REQ-016 SHALL have port active_idx  out  clog2(N_SPRINGS)  index of launching spring, valid with jump.
REQ-017 SHALL have port spring_compressed  out  N_SPRINGS  per-spring compressed flag for sprite select.

Function
REQ-018 SHALL store per spring: X, Y, valid bit, 2-bit state, tick counter, strength latch.
REQ-019 SHALL write X, Y, valid of spring cfg_idx on sys_clk when cfg_we=1, independent of frame_tick; cfg_idx >= N_SPRINGS ignored.
REQ-020 SHALL force the written spring to IDLE with counter cleared on that same edge (abort mid-operation, no jump).
REQ-021 SHALL define enabled(i) = valid and X <= scroll_right_border and X+SPRING_SIZE >= scroll_left_border, sums at COORD_W+1 bits.
REQ-022 SHALL define contact(i) = enabled(i) and char_Y+CHAR_SIZE == Y and horizontal overlap, overlap inclusive at both edges (char_X+CHAR_SIZE >= X and char_X <= X+SPRING_SIZE), sums at COORD_W+1 bits.
REQ-023 SHALL implement per spring states IDLE, COMPRESS, LAUNCH, COOLDOWN; transitions only on frame_tick unless stated.
REQ-024 IDLE: contact -> COMPRESS, counter=0, strength latch = jump_btn.
REQ-025 COMPRESS: contact lost -> IDLE (no jump); else counter+1, strength latch |= jump_btn; counter reaching HOLD_TICKS-1 -> LAUNCH.
REQ-026 LAUNCH: unconditionally -> COOLDOWN, counter=0; jump pulse asserted on the sys_clk cycle after entry into LAUNCH (registered).
REQ-027 COOLDOWN: counter+1; at COOLDOWN_TICKS-1 -> IDLE; contact ignored; continues if spring scrolls out of window.
REQ-028 spring_compressed[i] SHALL be 1 in COMPRESS and LAUNCH, registered.
REQ-029 jump SHALL be exactly one sys_clk cycle per launch event, never while frame_tick is low on the preceding edge.
REQ-030 Simultaneous launches: single jump pulse, active_idx = lowest launching index, jump_high = that spring's latch; other springs still go to COOLDOWN.
REQ-031 HOLD_TICKS or COOLDOWN_TICKS of 0 or 1 SHALL behave as 1 tick.

Reset
REQ-032 rst SHALL asynchronously clear all valid bits, X, Y, counters, latches; states to IDLE.
REQ-033 During and after reset: jump=0, jump_high=0, active_idx=0, spring_compressed=0.
REQ-034 rst asserted mid-COMPRESS or LAUNCH SHALL suppress any pending jump pulse.

Verification
REQ-035 Place spring 0 at (100,200), char (92,184), window 0..255, tick every 4 clk, jump_btn=0 -> spring_compressed[0] 4 ticks, one jump, jump_high=0, active_idx=0.
REQ-036 As REQ-035 with jump_btn pulsed during 2nd COMPRESS tick -> jump_high=1.
REQ-037 Char leaves (char_Y=183) after 2 COMPRESS ticks -> IDLE, no jump; re-contact in COOLDOWN of prior launch -> no compression until 8 ticks elapsed.
REQ-038 Springs 1 and 3 at identical positions under char -> one jump pulse, active_idx=1, both enter COOLDOWN.
REQ-039 Spring X=300, window 0..255, char aligned -> no contact; char_X=84 and 116 (edge overlap) -> contact.
REQ-040 Async rst mid-COMPRESS, and cfg_we to same spring mid-COMPRESS -> no jump, outputs 0, state IDLE.
